// File: rtl/pixel_pingpong_buf.sv
// ---------------------------------------------------------------------------
// pixel_pingpong_buf
//
// Double-buffered (ping-pong) pixel store between a pixel writer and a
// display scan-out reader. The writer fills one bank while the reader scans
// the other. The banks swap only once both sides have reported frame done.
//
// Optional feature macro: PIXBUF_OOB_ERR_EN
//   When defined, this adds output port oob_err. It is a sticky error flag,
//   cleared only by reset, that rises one cycle after any of these events:
//   an out-of-range write, an out-of-range read, or a write attempted while
//   wr_ready is low.
//
// Ports
//   clock      in   sole clock, all logic on posedge
//   reset      in   asynchronous, active-high
//   WE         in   write strobe
//   waddr      in   write pixel address (within the write bank)
//   WData      in   write data, low CH_W*CHANNELS bits stored
//   wr_ready   out  1 while the write bank accepts pixels (state FILL)
//   wr_done    in   pulse: writer finished its frame
//   RE         in   read strobe
//   raddr      in   read pixel address (within the read bank)
//   rd_done    in   pulse: reader finished its frame
//   oob_err    out  sticky misuse flag (only with PIXBUF_OOB_ERR_EN)
//   dout       out  read pixel, channel k at [k*CH_W +: CH_W]
//   dout_valid out  dout updated this cycle
//   rd_bank    out  bank being read; write bank is ~rd_bank
//   swap_pulse out  one-cycle pulse in the cycle after a bank swap
// ---------------------------------------------------------------------------
module pixel_pingpong_buf #(
    parameter int CH_W     = 8,
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 100,
    parameter int AW       = 20,
    parameter int WDATA_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     WE,
    input  logic [AW-1:0]            waddr,
    input  logic [WDATA_W-1:0]       WData,
    output logic                     wr_ready,
    input  logic                     wr_done,
    input  logic                     RE,
    input  logic [AW-1:0]            raddr,
    input  logic                     rd_done,
`ifdef PIXBUF_OOB_ERR_EN
    output logic                     oob_err,
`endif
    output logic [CH_W*CHANNELS-1:0] dout,
    output logic                     dout_valid,
    output logic                     rd_bank,
    output logic                     swap_pulse
);

    localparam int PW  = CH_W * CHANNELS;
    // Index width into one bank; addresses are range-checked before use.
    localparam int DAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2**AW, so compare with one extra bit.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Pixel storage: two banks, contents deliberately not reset.
    logic [PW-1:0] mem_q [0:1][0:DEPTH-1];

    state_e        state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic          wr_flag_q, wr_flag_d;
    logic          rd_flag_q, rd_flag_d;
    logic          swap_pulse_q, swap_pulse_d;
    logic          wr_ready_q, wr_ready_d;
    logic          dout_valid_q, dout_valid_d;
    logic [PW-1:0] dout_q, dout_d;

    logic          wr_in_range_s;
    logic          rd_in_range_s;
    logic          wr_en_s;
    logic          swap_s;
    logic [PW-1:0] rd_data_s;
    logic          unused_wdata_s;

    assign wr_in_range_s = ({1'b0, waddr} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, raddr} < DEPTH_W);
    // The reset term keeps memory untouched while the block is held in reset.
    assign wr_en_s       = WE & wr_ready_q & wr_in_range_s & ~reset;
    // A done pulse in the same cycle counts just like an already-set flag.
    assign swap_s        = (wr_flag_q | wr_done) & (rd_flag_q | rd_done);
    // Reads and writes in the swap cycle still use the pre-swap bank.
    assign rd_data_s     = mem_q[rd_bank_q][raddr[DAW-1:0]];
    // Only the low PW bits of WData are stored; the rest is intentionally dropped.
    assign unused_wdata_s = ^WData;

    // Write port into the current write bank.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[~rd_bank_q][waddr[DAW-1:0]] <= WData[PW-1:0];
        end
    end

    // Next-state logic for the swap handshake, the FSM and the read port.
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        wr_flag_d    = wr_flag_q;
        rd_flag_d    = rd_flag_q;
        swap_pulse_d = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        if (swap_s) begin
            rd_bank_d    = ~rd_bank_q;
            wr_flag_d    = 1'b0;
            rd_flag_d    = 1'b0;
            state_d      = ST_FILL;
            swap_pulse_d = 1'b1;
        end else begin
            wr_flag_d    = wr_flag_q | wr_done;
            rd_flag_d    = rd_flag_q | rd_done;
            swap_pulse_d = 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (wr_flag_q | wr_done) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_WAIT: state_d = ST_WAIT;
                default: state_d = ST_FILL;
            endcase
        end

        wr_ready_d = (state_d == ST_FILL);

        if (RE) begin
            dout_valid_d = 1'b1;
            if (rd_in_range_s) begin
                dout_d = rd_data_s;
            end else begin
                dout_d = {PW{1'b0}};
            end
        end else begin
            dout_valid_d = 1'b0;
            dout_d       = dout_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            rd_bank_q    <= 1'b0;
            wr_flag_q    <= 1'b0;
            rd_flag_q    <= 1'b1;   // empty bank 0 counts as already read
            swap_pulse_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            dout_valid_q <= 1'b0;
            dout_q       <= {PW{1'b0}};
        end else begin
            state_q      <= state_d;
            rd_bank_q    <= rd_bank_d;
            wr_flag_q    <= wr_flag_d;
            rd_flag_q    <= rd_flag_d;
            swap_pulse_q <= swap_pulse_d;
            wr_ready_q   <= wr_ready_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

`ifdef PIXBUF_OOB_ERR_EN
    logic oob_err_q, oob_err_d;

    // Sticky misuse detector; only reset clears it.
    always_comb begin
        oob_err_d = oob_err_q
                  | (WE & (~wr_in_range_s | ~wr_ready_q))
                  | (RE & ~rd_in_range_s);
    end

    // Misuse flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

    assign oob_err = oob_err_q;
`endif

    assign wr_ready   = wr_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rd_bank    = rd_bank_q;
    assign swap_pulse = swap_pulse_q;

endmodule
